zbc_iter: RTL and testbench

Iterative, parametrised carry-less multiply unit for the bit-manipulation unit. It implements the Zbc operations clmul, clmulh and clmulr over WIDTH-bit operands, retiring STEP multiplier bits per cycle. Every operation uses a start/busy/done handshake, and results stay registered between operations. It sits beside the single-cycle Zbb datapath in the BMU and serves the multicycle Zbc path that the combinational units cannot cover at speed.

---
 rtl/zbc_pkg.sv | 18 +
 rtl/clmul_step.sv | 39 +++
 rtl/zbc_iter.sv | 149 ++++++++++++++
 tb/tb_zbc_iter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zbc_pkg.sv
// Shared types and constants for the iterative carry-less multiplier.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package zbc_pkg;

    // Controller states: waiting, iterating over multiplier slices, result pulse.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    // ZBCSelect encodings; 2'b00 falls through to clmul.
    localparam logic [1:0] CLMUL  = 2'b01;
    localparam logic [1:0] CLMULR = 2'b10;
    localparam logic [1:0] CLMULH = 2'b11;

endpackage

// File: rtl/clmul_step.sv
// One carry-less multiply iteration: folds STEP multiplier bits into the product.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   p      : current 2*WIDTH product accumulator
//   a      : multiplicand
//   slice  : STEP multiplier bits, slice[0] has weight 2^offset
//   offset : bit position of slice[0] within the full multiplier
//   p_next : accumulator after xoring in the shifted partial products
module clmul_step
    import zbc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    parameter int OW    = $clog2(2 * WIDTH)
) (
    input  logic [2*WIDTH-1:0] p,
    input  logic [WIDTH-1:0]   a,
    input  logic [STEP-1:0]    slice,
    input  logic [OW-1:0]      offset,
    output logic [2*WIDTH-1:0] p_next
);

    logic [2*WIDTH-1:0] a_ext;

    assign a_ext = {{WIDTH{1'b0}}, a};

    // offset + i never exceeds WIDTH-1, so the widened multiplicand never loses bits.
    always_comb begin
        p_next = p;
        for (int i = 0; i < STEP; i++) begin
            if (slice[i]) begin
                p_next = p_next ^ (a_ext << (offset + OW'(i)));
            end
        end
    end

endmodule

// File: rtl/zbc_iter.sv
// Iterative Zbc unit (clmul / clmulh / clmulr), STEP multiplier bits per cycle.
// Latency: WIDTH/STEP busy cycles + 1 done cycle from accepted Start (fewer busy cycles with ZBC_EARLYOUT_EN).
// Backpressure: Start ignored while Busy; Flush aborts and wins over Start; result held between ops.
//
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   Start, Flush    : accept a new op in IDLE/DONE; abort any op in flight
//   A, B, ZBCSelect : multiplicand, multiplier, op select (captured on accept)
//   Busy, Done      : state decodes; Done is a one-cycle pulse with ZBCResult valid
//   ZBCResult       : registered result, updated only on completion or reset
// Build option: define ZBC_EARLYOUT_EN to finish as soon as the remaining multiplier bits are zero.
module zbc_iter
    import zbc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic             Flush,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       ZBCSelect,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] ZBCResult
);

    localparam int N  = WIDTH / STEP;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int OW = $clog2(2 * WIDTH);
    localparam int LS = $clog2(STEP);
    localparam logic [KW-1:0] KLAST = KW'(N - 1);

    state_t             state_q, state_d;
    logic               accept;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;      // multiplier, pre-shifted so bit 0 is the current slice
    logic [1:0]         sel_q;
    logic [2*WIDTH-1:0] p_q;
    logic [2*WIDTH-1:0] p_nxt;
    logic [KW-1:0]      k_q;
    logic [WIDTH-1:0]   res_q;
    logic [WIDTH-1:0]   res_sel;
    logic [WIDTH-1:0]   b_rest;
    logic [OW-1:0]      offset;
    logic               last_iter;

    assign offset = OW'(k_q) << LS;
    assign b_rest = b_q >> STEP;

`ifdef ZBC_EARLYOUT_EN
    // Nothing left to fold in once the unconsumed multiplier bits are all zero.
    assign last_iter = (k_q == KLAST) || (b_rest == '0);
`else
    assign last_iter = (k_q == KLAST);
`endif

    clmul_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .OW    (OW)
    ) u_step (
        .p      (p_q),
        .a      (a_q),
        .slice  (b_q[STEP-1:0]),
        .offset (offset),
        .p_next (p_nxt)
    );

    // Select from the product being formed this cycle so the result registers on the BUSY->DONE edge.
    always_comb begin
        res_sel = p_nxt[WIDTH-1:0];
        case (sel_q)
            CLMULH:  res_sel = p_nxt[2*WIDTH-1:WIDTH];
            CLMULR:  res_sel = p_nxt[2*WIDTH-2:WIDTH-1];
            default: res_sel = p_nxt[WIDTH-1:0];
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        if (Flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Start) begin
                        state_d = BUSY;
                        accept  = 1'b1;
                    end
                end
                BUSY: begin
                    if (last_iter) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (Start) begin
                        state_d = BUSY;
                        accept  = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q   <= '0;
            b_q   <= '0;
            sel_q <= '0;
            p_q   <= '0;
            k_q   <= '0;
            res_q <= '0;
        end else if (accept) begin
            a_q   <= A;
            b_q   <= B;
            sel_q <= ZBCSelect;
            p_q   <= '0;
            k_q   <= '0;
        end else if (state_q == BUSY && !Flush) begin
            p_q <= p_nxt;
            b_q <= b_rest;
            k_q <= k_q + 1'b1;
            if (last_iter) begin
                res_q <= res_sel;
            end
        end
    end

    assign Busy      = (state_q == BUSY);
    assign Done      = (state_q == DONE);
    assign ZBCResult = res_q;

endmodule

// File: tb/tb_zbc_iter.sv
module tb_zbc_iter;
    import zbc_pkg::*;

    localparam int W = 32;
    localparam int S = 4;
    localparam int N = W / S;

    logic         clk;
    logic         reset;
    logic         Start;
    logic         Flush;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [1:0]   ZBCSelect;
    logic         Busy;
    logic         Done;
    logic [W-1:0] ZBCResult;

    int           vectors;
    int           miscompares;
    int           cyc;
    int           done_cyc;
    logic [W-1:0] last_res;

    zbc_iter #(.WIDTH(W), .STEP(S)) dut (
        .clk       (clk),
        .reset     (reset),
        .Start     (Start),
        .Flush     (Flush),
        .A         (A),
        .B         (B),
        .ZBCSelect (ZBCSelect),
        .Busy      (Busy),
        .Done      (Done),
        .ZBCResult (ZBCResult)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: full GF(2) product built bit by bit, then the architectural window.
    function automatic logic [W-1:0] ref_res(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [1:0] sel);
        logic [2*W-1:0] p;
        p = '0;
        for (int i = 0; i < W; i++)
            if (b[i]) p = p ^ ({{W{1'b0}}, a} << i);
        case (sel)
            2'b11:   return p[2*W-1:W];
            2'b10:   return p[2*W-2:W-1];
            default: return p[W-1:0];
        endcase
    endfunction

    function automatic int exp_busy(input logic [W-1:0] b);
`ifdef ZBC_EARLYOUT_EN
        int msb;
        msb = -1;
        for (int i = 0; i < W; i++)
            if (b[i]) msb = i;
        if (msb < 0) return 1;
        return (msb + S) / S;
`else
        return N + (b === 'x ? 1 : 0);
`endif
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Called at a negedge; drives Start that cycle and checks every following cycle through Done.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] sel);
        logic [W-1:0] exp;
        int nb;
        exp = ref_res(a, b, sel);
        nb  = exp_busy(b);
        Start = 1'b1; A = a; B = b; ZBCSelect = sel;
        @(posedge clk);
        @(negedge clk);
        Start = 1'b0; A = $urandom; B = $urandom; ZBCSelect = 2'($urandom);
        for (int c = 1; c <= nb; c++) begin
            if (c > 1) @(negedge clk);
            vectors++;
            if (Busy !== 1'b1 || Done !== 1'b0 || ZBCResult !== last_res) begin
                miscompares++;
                $display("FAIL busy_phase a=%h b=%h cycle=%0d: Busy=%b Done=%b res=%h, want Busy=1 Done=0 res=%h",
                         a, b, c, Busy, Done, ZBCResult, last_res);
            end
        end
        @(negedge clk);
        vectors++;
        if (Done !== 1'b1 || Busy !== 1'b0 || ZBCResult !== exp) begin
            miscompares++;
            $display("FAIL done_phase a=%h b=%h sel=%b: Done=%b Busy=%b res=%h, want Done=1 Busy=0 res=%h",
                     a, b, sel, Done, Busy, ZBCResult, exp);
        end
        last_res = exp;
        done_cyc = cyc;
    endtask

    task automatic test_reset;
        reset = 1'b1; Start = 1'b0; Flush = 1'b0; A = '0; B = '0; ZBCSelect = '0;
        idle(2);
        vectors++;
        if (Busy !== 1'b0 || Done !== 1'b0 || ZBCResult !== '0) begin
            miscompares++;
            $display("FAIL reset_state: Busy=%b Done=%b res=%h, want 0 0 0", Busy, Done, ZBCResult);
        end
        reset = 1'b0;
        last_res = '0;
        idle(1);
    endtask

    task automatic test_clmul;
        run_op(32'h3, 32'h3, CLMUL);
        vectors++;
        if (ZBCResult !== 32'h5) begin
            miscompares++;
            $display("FAIL clmul_3x3: got %h want 00000005", ZBCResult);
        end
        idle(1);
    endtask

    task automatic test_clmulh_clmulr;
        run_op(32'h8000_0000, 32'h8000_0000, CLMULH);
        vectors++;
        if (ZBCResult !== 32'h4000_0000) begin
            miscompares++;
            $display("FAIL clmulh_msb: got %h want 40000000", ZBCResult);
        end
        idle(1);
        run_op(32'h8000_0000, 32'h8000_0000, CLMULR);
        vectors++;
        if (ZBCResult !== 32'h8000_0000) begin
            miscompares++;
            $display("FAIL clmulr_msb: got %h want 80000000", ZBCResult);
        end
        idle(2);
    endtask

    task automatic test_random;
        logic [W-1:0] a, b;
        for (int t = 0; t < 40; t++) begin
            a = $urandom;
            b = $urandom;
            // Vary the multiplier's top set bit so short early-out runs appear too.
            b = b >> $urandom_range(0, W);
            run_op(a, b, 2'($urandom));
            idle($urandom_range(0, 2));
        end
    endtask

    task automatic test_flush;
        int seen;
        Start = 1'b1; A = 32'hDEAD_BEEF; B = 32'hFFFF_FFFF; ZBCSelect = CLMUL;
        @(posedge clk);
        @(negedge clk); Start = 1'b0;   // c+1
        @(negedge clk);                 // c+2
        @(negedge clk); Flush = 1'b1;   // c+3
        @(negedge clk); Flush = 1'b0;   // c+4
        vectors++;
        if (Busy !== 1'b0 || Done !== 1'b0 || ZBCResult !== last_res) begin
            miscompares++;
            $display("FAIL flush_abort: Busy=%b Done=%b res=%h, want 0 0 %h", Busy, Done, ZBCResult, last_res);
        end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (Done !== 1'b0 || Busy !== 1'b0 || ZBCResult !== last_res) seen++;
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL flush_quiet: %0d bad cycles after flush, want 0", seen);
        end
        Start = 1'b1; Flush = 1'b1; A = 32'h1; B = 32'h1;
        @(negedge clk);
        Start = 1'b0; Flush = 1'b0;
        vectors++;
        if (Busy !== 1'b0 || Done !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_beats_start: Busy=%b Done=%b, want 0 0", Busy, Done);
        end
        idle(1);
    endtask

    task automatic test_back_to_back;
        int first_done;
        int want;
        logic [W-1:0] b2;
        run_op(32'hA5A5_0F0F, 32'h1234_5679, CLMULH);
        first_done = done_cyc;
        b2 = 32'h7;
        run_op(32'h5, b2, CLMUL);
        vectors++;
        if (ZBCResult !== 32'h1B) begin
            miscompares++;
            $display("FAIL b2b_result: got %h want 0000001b", ZBCResult);
        end
        want = exp_busy(b2) + 1;
        vectors++;
        if (done_cyc - first_done != want) begin
            miscompares++;
            $display("FAIL b2b_spacing: got %0d cycles want %0d", done_cyc - first_done, want);
        end
        idle(1);
    endtask

    task automatic test_earlyout;
        int want;
        int start_cyc;
        start_cyc = cyc;
        run_op(32'h1234, 32'h1, CLMUL);
`ifdef ZBC_EARLYOUT_EN
        want = 2;
`else
        want = 9;
`endif
        vectors++;
        if (done_cyc - start_cyc != want) begin
            miscompares++;
            $display("FAIL earlyout_latency: got %0d want %0d", done_cyc - start_cyc, want);
        end
        vectors++;
        if (ZBCResult !== 32'h1234) begin
            miscompares++;
            $display("FAIL earlyout_result: got %h want 00001234", ZBCResult);
        end
        idle(1);
        run_op(32'hCAFE_F00D, 32'h0, CLMUL);
        idle(1);
    endtask

    task automatic test_reset_mid;
        int seen;
        Start = 1'b1; A = 32'h1357_9BDF; B = 32'hF000_0001; ZBCSelect = CLMULR;
        @(posedge clk);
        @(negedge clk); Start = 1'b0;   // c+1
        idle(3);                        // c+4
        reset = 1'b1;
        #1;
        vectors++;
        if (Busy !== 1'b0 || Done !== 1'b0 || ZBCResult !== '0) begin
            miscompares++;
            $display("FAIL reset_mid: Busy=%b Done=%b res=%h, want 0 0 0", Busy, Done, ZBCResult);
        end
        @(negedge clk);
        reset = 1'b0;
        last_res = '0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (Done !== 1'b0 || Busy !== 1'b0) seen++;
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL reset_mid_quiet: %0d cycles with Busy/Done after reset, want 0", seen);
        end
        run_op(32'h3, 32'h3, 2'b00);
        idle(1);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        done_cyc    = 0;
        last_res    = '0;
        reset = 1'b1; Start = 1'b0; Flush = 1'b0; A = '0; B = '0; ZBCSelect = '0;
        @(negedge clk);
        test_reset;
        test_clmul;
        test_clmulh_clmulr;
        test_random;
        test_flush;
        test_back_to_back;
        test_earlyout;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
